// File: rtl/win_line_scanner.sv
// rtl/win_line_scanner.sv - sequential in-a-row scanner, one field cell per clock
// Reports the first winning line and optionally counts every winning window.
module win_line_scanner #(
   parameter int ROWS         = 6,
   parameter int COLS         = 7,
   parameter int IN_A_ROW_LEN = 4,
   parameter int CNT_W        = 8,
   localparam int N           = ROWS * COLS,
   localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic [N-1:0]     i_field,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_found,
   output logic [RW-1:0]    o_row,
   output logic [CW-1:0]    o_col,
   output logic [1:0]       o_dir,
   output logic [CNT_W-1:0] o_line_cnt
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state, state_nxt;
   logic [N-1:0]     field;
   logic             mode;
   logic [RW-1:0]    r;
   logic [CW-1:0]    c;
   logic [3:0]       hit;
   logic             any_hit, last_cell;
   logic [1:0]       first_dir;
   logic [2:0]       hit_n;
   logic [CNT_W+2:0] cnt_sum;
   logic [CNT_W-1:0] cnt_sat;

   // Window from (r0,c0) stepping (dr,dc); any cell outside the field kills the match.
   function automatic logic win(input logic [N-1:0] f, input int r0, input int c0,
                                input int dr, input int dc);
      logic         ok;
      logic [N-1:0] sh;
      int           rr, cc;
      ok = 1'b1;
      for (int j = 0; j < IN_A_ROW_LEN; j++) begin
         rr = r0 + j * dr;
         cc = c0 + j * dc;
         if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
            ok = 1'b0;
         end else begin
            sh = f >> (rr * COLS + cc);
            ok = ok & sh[0];
         end
      end
      return ok;
   endfunction

   always_comb begin
      hit[0]    = win(field, int'(r), int'(c), 0, 1);
      hit[1]    = win(field, int'(r), int'(c), 1, 0);
      hit[2]    = win(field, int'(r), int'(c), 1, 1);
      hit[3]    = win(field, int'(r), int'(c), 1, -1);
      any_hit   = |hit;
      last_cell = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));
      if (hit[0])      first_dir = 2'd0;
      else if (hit[1]) first_dir = 2'd1;
      else if (hit[2]) first_dir = 2'd2;
      else             first_dir = 2'd3;
      hit_n   = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
      cnt_sum = {3'b000, o_line_cnt} + (CNT_W+3)'(hit_n);
      cnt_sat = (cnt_sum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (i_start) state_nxt = SCAN;
         SCAN:       if ((!mode && any_hit) || last_cell) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         field      <= '0;
         mode       <= 1'b0;
         r          <= '0;
         c          <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_found    <= 1'b0;
         o_row      <= '0;
         o_col      <= '0;
         o_dir      <= '0;
         o_line_cnt <= '0;
      end else begin
         o_done <= 1'b0;
         if (state != SCAN && i_start) begin
            field      <= i_field;
            mode       <= i_mode;
            r          <= '0;
            c          <= '0;
            o_busy     <= 1'b1;
            o_found    <= 1'b0;
            o_row      <= '0;
            o_col      <= '0;
            o_dir      <= '0;
            o_line_cnt <= '0;
         end else if (state == SCAN) begin
            // Only the first match in scan order is recorded.
            if (any_hit && !o_found) begin
               o_found <= 1'b1;
               o_row   <= r;
               o_col   <= c;
               o_dir   <= first_dir;
            end
            if (mode)         o_line_cnt <= cnt_sat;
            else if (any_hit) o_line_cnt <= CNT_W'(1);
            if (c == CW'(COLS - 1)) begin
               c <= '0;
               r <= r + 1'b1;
            end else begin
               c <= c + 1'b1;
            end
            if (state_nxt == DONE) begin
               o_busy <= 1'b0;
               o_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_win_line_scanner.sv
// tb/tb_win_line_scanner.sv - directed self-checking bench for win_line_scanner
module tb_win_line_scanner;

   localparam int N = 42;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [N-1:0]  field = '0;

   logic          busy, done, found;
   logic [2:0]    row, col;
   logic [1:0]    dir;
   logic [7:0]    cnt;
   logic          s_busy, s_done, s_found;
   logic [2:0]    s_row, s_col;
   logic [1:0]    s_dir;
   logic [2:0]    s_cnt;

   int total = 0;
   int bad = 0;
   int n, busy_n, done_n;
   logic [N-1:0] f;

   always #5 clk = ~clk;

   win_line_scanner u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_field(field),
      .o_busy(busy), .o_done(done), .o_found(found), .o_row(row), .o_col(col),
      .o_dir(dir), .o_line_cnt(cnt)
   );

   win_line_scanner #(.CNT_W(3)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_field(field),
      .o_busy(s_busy), .o_done(s_done), .o_found(s_found), .o_row(s_row), .o_col(s_col),
      .o_dir(s_dir), .o_line_cnt(s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [N-1:0] fv, input logic mv);
      @(negedge clk);
      field = fv;
      mode  = mv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after acceptance until o_done; optionally pokes i_start at edge count `poke`.
   task automatic wait_done(input int poke);
      n = 0;
      busy_n = 0;
      while (!done && n < 200) begin
         if (busy) busy_n++;
         if (n == poke) begin
            start = 1'b1;
            field = '0;
            mode  = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic chk_result(input string tag, input int f_e, input int r_e, input int c_e,
                             input int d_e, input int n_e, input int k_e);
      chk({tag, "_latency"}, n, n_e);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_found"}, found, f_e);
      chk({tag, "_row"}, row, r_e);
      chk({tag, "_col"}, col, c_e);
      chk({tag, "_dir"}, dir, d_e);
      chk({tag, "_cnt"}, cnt, k_e);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      chk("rst_row", row, 0);
      chk("rst_col", col, 0);
      chk("rst_dir", dir, 0);
      chk("rst_cnt", cnt, 0);
      rst = 1'b0;

      // Horizontal run in row 2, columns 1..4
      accept(42'hF << 15, 1'b0);
      chk("hz_busy_after_accept", busy, 1);
      wait_done(-1);
      chk_result("hz", 1, 2, 1, 0, 16, 1);
      chk("hz_busy_cycles", busy_n, 16);
      @(posedge clk);
      #1;
      chk("hz_done_one_cycle", done, 0);
      chk("hz_row_held", row, 2);

      // Empty field runs the full scan
      accept('0, 1'b0);
      wait_done(-1);
      chk_result("empty", 0, 0, 0, 0, 42, 0);
      chk("empty_busy_cycles", busy_n, 42);

      // Down-left diagonal from the top-right corner
      f = '0;
      f[6] = 1'b1; f[12] = 1'b1; f[18] = 1'b1; f[24] = 1'b1;
      accept(f, 1'b0);
      wait_done(-1);
      chk_result("dl", 1, 0, 6, 3, 7, 1);

      // A run that would only exist by wrapping row 0 into row 1
      f = '0;
      f[5] = 1'b1; f[6] = 1'b1; f[7] = 1'b1; f[8] = 1'b1;
      accept(f, 1'b0);
      wait_done(-1);
      chk_result("wrap", 0, 0, 0, 0, 42, 0);

      // Count mode: full row 0 plus full column 0 gives 4 + 3 windows
      f = 42'h7F;
      f[7] = 1'b1; f[14] = 1'b1; f[21] = 1'b1; f[28] = 1'b1; f[35] = 1'b1;
      accept(f, 1'b1);
      wait_done(-1);
      chk_result("count", 1, 0, 0, 0, 42, 7);

      // All ones: 24 + 21 + 12 + 12 windows; 3-bit counter saturates at 7
      accept('1, 1'b1);
      wait_done(-1);
      chk_result("full", 1, 0, 0, 0, 42, 69);
      chk("sat_cnt", s_cnt, 7);
      chk("sat_found", s_found, 1);
      chk("sat_row", s_row, 0);
      chk("sat_col", s_col, 0);
      chk("sat_dir", s_dir, 0);

      // i_start during SCAN is ignored
      accept(42'hF << 15, 1'b0);
      wait_done(5);
      chk_result("midstart", 1, 2, 1, 0, 16, 1);

      // Reset at cycle 10 of a scan aborts with no done
      accept('0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_found", found, 0);
      chk("abort_cnt", cnt, 0);
      done_n = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (done || busy) done_n++;
      end
      chk("abort_idle", done_n, 0);

      // Restart in the same cycle as o_done
      accept(42'hF << 15, 1'b0);
      wait_done(-1);
      chk("back2back_done", done, 1);
      f = '0;
      f[6] = 1'b1; f[12] = 1'b1; f[18] = 1'b1; f[24] = 1'b1;
      field = f;
      mode  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_done_low", done, 0);
      chk("b2b_found_clr", found, 0);
      chk("b2b_cnt_clr", cnt, 0);
      chk("b2b_row_clr", row, 0);
      wait_done(-1);
      chk_result("b2b", 1, 0, 6, 3, 7, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
